// File: rtl/pwm_capture.sv
// PWM receiver: measures each full period of pwm_i and reports on/period counts,
// flagging a constant-level input through a period-length timeout.
module pwm_capture #(
  parameter int PWM_BW      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              en_i,
  input  logic              pwm_i,
  output logic [PWM_BW-1:0] onCnt_o,
  output logic [PWM_BW-1:0] periodCnt_o,
  output logic              valid_o,
  output logic              stuck_o,
  output logic              level_o
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    STUCK
  } state_e;

  localparam logic [PWM_BW:0]   TIMEOUT  = {1'b1, {PWM_BW{1'b0}}};
  localparam logic [PWM_BW-1:0] ONES     = {PWM_BW{1'b1}};
  localparam logic [PWM_BW-1:0] HI_START = {{(PWM_BW-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [PWM_BW:0]        per_cnt_q, per_cnt_d;
  logic [PWM_BW-1:0]      hi_cnt_q, hi_cnt_d;
  logic [PWM_BW-1:0]      on_cnt_q, on_cnt_d;
  logic [PWM_BW-1:0]      period_cnt_q, period_cnt_d;
  logic                   valid_q, valid_d;
  logic                   stuck_q, stuck_d;

  logic level;
  logic rise;
  logic hi_inc;

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = level & ~prev_q;
  // The high counter is a period-bounded count; saturation only guards against overflow.
  assign hi_inc = level & ~(&hi_cnt_q);

  // NOTE: every flop, including the synchronizer, is cleared by the async reset so
  // that no spurious edge is seen on the first cycle after release.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync_q       <= '0;
      prev_q       <= 1'b0;
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      on_cnt_q     <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      prev_q       <= level;
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      on_cnt_q     <= on_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
    end
  end

  // NOTE: every signal driven here gets a default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    on_cnt_d     = on_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;

    if (!en_i) begin
      state_d   = IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          // First edge only arms the measurement; the period before it is partial.
          if (rise) begin
            hi_cnt_d = HI_START;
            state_d  = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            on_cnt_d     = hi_cnt_q;
            period_cnt_d = per_cnt_q[PWM_BW-1:0];
            valid_d      = 1'b1;
            stuck_d      = 1'b0;
            per_cnt_d    = '0;
            hi_cnt_d     = HI_START;
          end else if (per_cnt_q == TIMEOUT) begin
            state_d      = STUCK;
            stuck_d      = 1'b1;
            period_cnt_d = ONES;
            on_cnt_d     = level ? ONES : '0;
            valid_d      = 1'b1;
          end else begin
            per_cnt_d = per_cnt_q + 1'b1;
            hi_cnt_d  = hi_cnt_q + {{(PWM_BW-1){1'b0}}, hi_inc};
          end
        end
        STUCK: begin
          if (rise) begin
            per_cnt_d = '0;
            hi_cnt_d  = HI_START;
            state_d   = MEASURE;
          end
        end
        default: begin
          state_d   = IDLE;
          per_cnt_d = '0;
          hi_cnt_d  = '0;
        end
      endcase
    end
  end

  assign onCnt_o     = on_cnt_q;
  assign periodCnt_o = period_cnt_q;
  assign valid_o     = valid_q;
  assign stuck_o     = stuck_q;
  assign level_o     = level;

endmodule
